stage_screen_sequencer: RTL
===========================

Name: stage_screen_sequencer

Overview:
- Sits between the stage-banner drawer (80x40 ROM image placed at (39,39)) and the VGA adapter.
- On a `go` pulse it runs four phases in order: clear the 160x120 screen, release the banner drawer and forward its pixel stream, hold the banner for a fixed number of frames, then erase the banner region.
- It generates the VGA plot strobe itself, because the drawer provides no per-pixel valid signal.

Parameters:
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- BANNER_X0, 39, banner left edge
- BANNER_Y0, 39, banner top edge
- BANNER_W, 80, banner width
- BANNER_H, 40, banner height
- BANNER_LAT, 2, cycles from banner_resetn rising to first valid drawer pixel
- HOLD_FRAMES, 120, frame_tick pulses the banner stays visible
- CLEAR_COLOUR, 9'h000, fill colour for clear and erase

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  single-cycle start request
- frame_tick  in  1  one-cycle pulse per displayed frame
- banner_done  in  1  drawer completion flag
- banner_colour  in  9  drawer pixel colour
- banner_x  in  8  drawer pixel x
- banner_y  in  7  drawer pixel y
- banner_resetn  out  1  active-low run/hold control to the drawer
- vga_x  out  8  pixel x to VGA
- vga_y  out  7  pixel y to VGA
- vga_colour  out  9  pixel colour to VGA
- vga_plot  out  1  write strobe to VGA
- busy  out  1  high in every state except IDLE
- seq_done  out  1  one-cycle pulse when the sequence completes
- banner_err  out  1  sticky drawer-timeout flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - All counters = 0.
  - banner_resetn = 0 (drawer held in reset).
  - vga_plot = 0, vga_x/vga_y/vga_colour = 0.
  - busy = 0, seq_done = 0, banner_err = 0.
- Output timing: all vga_* outputs are registered, one cycle of latency from the internal scan counter or the drawer inputs.
- IDLE: go=1 → CLEAR, with the scan counters zeroed. go is ignored in every other state.
- CLEAR:
  - Raster scan x=0..159 inner, y=0..119 outer, one pixel per cycle, plot=1, colour=CLEAR_COLOUR.
  - 19200 plots total.
  - After (159,119) is issued → BANNER, with the phase counter k=0.
- BANNER:
  - banner_resetn=1; k increments every cycle, and the first BANNER cycle is k=0.
  - For k in [BANNER_LAT, BANNER_LAT+3199]: forward banner_x/y/colour with plot=1. At all other k, plot=0.
  - Leave when banner_done=1 and k > BANNER_LAT+3199 → HOLD, with banner_resetn=0 on that same transition. This prevents the drawer from restarting its scan.
  - Timeout: if k reaches BANNER_LAT+3200+8 without banner_done, set banner_err=1 (sticky until reset) and → HOLD anyway.
- HOLD:
  - plot=0; count frame_tick pulses.
  - After HOLD_FRAMES pulses → ERASE.
  - HOLD_FRAMES=0 → ERASE on the next cycle.
- ERASE:
  - Scan x=39..118, y=39..78 (region from the BANNER_* parameters).
  - plot=1, colour=CLEAR_COLOUR, 3200 plots.
  - → DONE.
- DONE: seq_done=1 for exactly one cycle → IDLE. busy falls in the same cycle that IDLE is entered.
- Width rules:
  - Screen x counter is 8 bits, screen y is 7 bits.
  - The banner phase counter k is 12 bits and must count to 3210 without wrap.
  - Erase coordinates are computed as base + offset in 8/7 bits; no overflow for the default parameters.
- Reset mid-operation: any state returns to IDLE asynchronously, vga_plot drops immediately, and banner_resetn=0.
- frame_tick outside HOLD is ignored. banner_done outside BANNER is ignored.

Decomposition:
- Package stage_draw_pkg holds:
  - the state encoding (IDLE, CLEAR, BANNER, HOLD, ERASE, DONE);
  - SCREEN_W/H and BANNER geometry constants;
  - CLEAR_COLOUR.
- One sub-module, rect_scanner: a parameterised x0/y0/w/h raster counter with start/last outputs, instantiated for CLEAR and ERASE (shared, re-armed per phase).

Test Plan:
- go pulse after reset, drawer model (2-cycle latency, done at last pixel):
  - expect 19200 plots, all colour 0, first (0,0), last (159,119);
  - then exactly 3200 forwarded plots, first (39,39), last (118,78).
- HOLD_FRAMES=3, frame_tick every 100 cycles → ERASE starts 1 cycle after the 3rd tick; 3200 black plots over x 39..118, y 39..78; seq_done pulses once; busy low the following cycle.
- go held high during CLEAR and pulsed during HOLD → no restart; total plot count unchanged (25600).
- Drawer never asserts banner_done → banner_err=1 at BANNER k=3210; HOLD and ERASE still complete; err persists until reset.
- reset asserted mid-BANNER at k=1000 → vga_plot=0 and banner_resetn=0 asynchronously; after release, a new go replays the full sequence from (0,0).
- banner_resetn checked low from the HOLD transition onward → drawer produces no second scan; no plots issued during HOLD.

Source files
------------

// File: rtl/stage_draw_pkg.sv
// rtl/stage_draw_pkg.sv - shared state encoding, geometry and colour constants
package stage_draw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    BANNER = 3'd2,
    HOLD   = 3'd3,
    ERASE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] SCREEN_W  = 8'd160;
  localparam logic [6:0] SCREEN_H  = 7'd120;
  localparam logic [7:0] BANNER_X0 = 8'd39;
  localparam logic [6:0] BANNER_Y0 = 7'd39;
  localparam logic [7:0] BANNER_W  = 8'd80;
  localparam logic [6:0] BANNER_H  = 7'd40;

  localparam int BANNER_PIXELS = int'(BANNER_W) * int'(BANNER_H);

  localparam logic [8:0] CLEAR_COLOUR = 9'h000;

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - raster counter over a rectangle with run-time geometry
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        re-arm: offsets return to (0,0); has priority over en
//   en           advance one pixel (x inner, y outer)
//   x0, y0       rectangle origin
//   w, h         rectangle size (non-zero)
//   x, y         current pixel = origin + offset
//   last         current pixel is the bottom-right corner
module rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] ox;
  logic [6:0] oy;
  logic       x_end;
  logic       y_end;

  assign x_end = (ox == w - 8'd1);
  assign y_end = (oy == h - 7'd1);
  assign last  = x_end && y_end;
  assign x     = x0 + ox;
  assign y     = y0 + oy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox <= '0;
      oy <= '0;
    end else if (start) begin
      ox <= '0;
      oy <= '0;
    end else if (en) begin
      if (x_end) begin
        ox <= '0;
        oy <= y_end ? 7'd0 : oy + 7'd1;
      end else begin
        ox <= ox + 8'd1;
      end
    end
  end

endmodule

// File: rtl/stage_screen_sequencer.sv
// rtl/stage_screen_sequencer.sv - clear / banner / hold / erase sequencer in front of the VGA adapter
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   go               start request, honoured only in IDLE
//   frame_tick       one pulse per displayed frame, counted only in HOLD
//   banner_done      drawer completion flag, observed only in BANNER
//   banner_colour/x/y drawer pixel stream
//   banner_resetn    active-low run control to the drawer
//   vga_x/y/colour   registered pixel to VGA
//   vga_plot         registered write strobe to VGA
//   busy             high outside IDLE
//   seq_done         one-cycle pulse while in DONE
//   banner_err       sticky drawer timeout
module stage_screen_sequencer
  import stage_draw_pkg::*;
#(
  parameter int BANNER_LAT  = 2,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       frame_tick,
  input  logic       banner_done,
  input  logic [8:0] banner_colour,
  input  logic [7:0] banner_x,
  input  logic [6:0] banner_y,
  output logic       banner_resetn,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       seq_done,
  output logic       banner_err
);

  // Forwarding window in phase-counter units, plus a small grace period
  // after the last expected pixel before declaring the drawer hung.
  localparam logic [11:0] K_FIRST   = 12'(BANNER_LAT);
  localparam logic [11:0] K_LAST    = 12'(BANNER_LAT + BANNER_PIXELS - 1);
  localparam logic [11:0] K_TIMEOUT = 12'(BANNER_LAT + BANNER_PIXELS + 8);
  localparam logic [15:0] HOLD_LAST = (HOLD_FRAMES == 0) ? 16'd0 : 16'(HOLD_FRAMES - 1);

  state_t      state;
  logic [11:0] k;
  logic [15:0] hold_cnt;

  logic        scan_en;
  logic        scan_start;
  logic        scan_erase;
  logic [7:0]  scan_x;
  logic [6:0]  scan_y;
  logic        scan_last;

  // One scanner serves both fill phases; it is held at offset zero in every
  // other state so each fill starts from its rectangle's top-left corner.
  assign scan_en    = (state == CLEAR) || (state == ERASE);
  assign scan_start = !scan_en;
  assign scan_erase = (state == ERASE);

  rect_scanner u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .en    (scan_en),
    .x0    (scan_erase ? BANNER_X0 : 8'd0),
    .y0    (scan_erase ? BANNER_Y0 : 7'd0),
    .w     (scan_erase ? BANNER_W  : SCREEN_W),
    .h     (scan_erase ? BANNER_H  : SCREEN_H),
    .x     (scan_x),
    .y     (scan_y),
    .last  (scan_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      k             <= '0;
      hold_cnt      <= '0;
      banner_resetn <= 1'b0;
      vga_x         <= '0;
      vga_y         <= '0;
      vga_colour    <= '0;
      vga_plot      <= 1'b0;
      busy          <= 1'b0;
      seq_done      <= 1'b0;
      banner_err    <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end

        CLEAR: begin
          vga_x      <= scan_x;
          vga_y      <= scan_y;
          vga_colour <= CLEAR_COLOUR;
          vga_plot   <= 1'b1;
          if (scan_last) begin
            state         <= BANNER;
            k             <= '0;
            banner_resetn <= 1'b1;
          end
        end

        BANNER: begin
          k <= k + 12'd1;
          // The drawer has no valid strobe; its pixels are trusted only
          // inside the window that follows its fixed start-up latency.
          if (k >= K_FIRST && k <= K_LAST) begin
            vga_x      <= banner_x;
            vga_y      <= banner_y;
            vga_colour <= banner_colour;
            vga_plot   <= 1'b1;
          end
          // Dropping banner_resetn on the way out keeps the drawer from
          // starting a second scan while the banner is on screen.
          if (banner_done && k > K_LAST) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            banner_resetn <= 1'b0;
          end else if (k == K_TIMEOUT) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            banner_resetn <= 1'b0;
            banner_err    <= 1'b1;
          end
        end

        HOLD: begin
          if (HOLD_FRAMES == 0 || (frame_tick && hold_cnt == HOLD_LAST)) begin
            state <= ERASE;
          end else if (frame_tick) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end

        ERASE: begin
          vga_x      <= scan_x;
          vga_y      <= scan_y;
          vga_colour <= CLEAR_COLOUR;
          vga_plot   <= 1'b1;
          if (scan_last) begin
            state    <= DONE;
            seq_done <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
